multichan_mix_pipe: RTL and testbench
=====================================

Name: multichan_mix_pipe

Overview:
- Parametrised successor of the 15-channel random-datapath tops. Generalises channel count, data width and pipeline depth, and adds a valid/ready handshake, runtime mode select and per-channel accumulation state.
- Each accepted input word is assigned round-robin to a channel and combined with that channel's accumulator. The result passes through a stallable DEPTH-stage register pipeline, and leaves tagged with its channel index.

Parameters:
- WIDTH, 32, data width in bits (>=8).
- CHANNEL, 15, number of channel accumulators (>=2).
- DEPTH, 3, output pipeline stages (>=1); this equals the latency.
- CW, $clog2(CHANNEL), channel index width (derived, localparam).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in  in  WIDTH  input data word.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept the input word this cycle.
- mode  in  2  operation, sampled with each accepted word.
- out  out  WIDTH  result word.
- out_chan  out  CW  channel index of the result.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (rst=1 at an edge):
  - all CHANNEL accumulators cleared to 0 and the channel pointer ptr set to 0;
  - all stage valid bits cleared to 0;
  - out=0, out_chan=0, out_valid=0.
  - Reset overrides every other event in that cycle. Words in flight are discarded, not flushed out.
- Advance condition: adv = !out_valid || out_ready.
  - in_ready = adv (combinational) and is 0 while rst=1.
  - The whole pipeline shifts only when adv=1. There is no bubble collapse.
- Accept: fires when in_valid && in_ready. On that edge:
  - r = f(mode, acc[ptr], in, ptr);
  - acc[ptr] <= r;
  - stage1 <= {r, ptr, valid=1};
  - ptr <= (ptr==CHANNEL-1) ? 0 : ptr+1.
- If adv=1 but no word is accepted, stage1 valid <= 0 (a bubble enters the pipeline).
- mode encodings:
  - 0 PASS: r = in.
  - 1 XOR: r = acc ^ in.
  - 2 ADD: r = acc + in, modulo 2^WIDTH, carry dropped.
  - 3 ROTX: r = acc ^ rotl(in, ptr mod WIDTH).
- Latency: a word accepted at edge k appears on out/out_chan with out_valid=1 after edge k+DEPTH-1 when there is no stall. A DEPTH=1 configuration drives the outputs directly from stage1.
- Stall: while out_valid && !out_ready:
  - out, out_chan and all stages hold stable;
  - in_ready=0, so no accumulator or ptr update occurs.
- Simultaneous events: the output handshake and an input accept in the same cycle are legal. This gives full throughput of one word per cycle.
- Mode changes mid-stream affect only words accepted after the change. Accumulators are never cleared by a mode change.
- Wrap-around: after CHANNEL accepts, ptr returns to 0 and acc[0] keeps its prior value.

Optional Feature:
- Macro MIX_SIG_EN.
- When defined:
  - adds output port sig (WIDTH);
  - sig is a running XOR of every out word completing the handshake (out_valid && out_ready);
  - sig resets to 0.
- When undefined: the port and its logic are absent, and the behaviour is otherwise identical.

Decomposition:
- Shared package mix_pkg:
  - mode typedef/enum (MODE_PASS, MODE_XOR, MODE_ADD, MODE_ROTX);
  - a rotl function;
  - default-parameter constants.
- One natural sub-module, mix_alu: combinational f(mode, acc, in, idx), parametrised by WIDTH and CW, instantiated once.
- The stage pipeline is a generate loop in the top.

Test Plan (WIDTH=32, CHANNEL=15, DEPTH=3, out_ready=1 unless noted):
- Reset, then mode=0, in=0xabcdefab for one cycle -> out_valid=1 with out=0xabcdefab, out_chan=0 after the third edge from accept; in_ready=1 throughout.
- mode=2, in=0x12345678 held for 16 accepts -> words 1..15 give out_chan 0..14 with out=0x12345678; word 16 gives out_chan=0 with out=0x2468acf0 (wrap-around).
- Reset, mode=3, in=0xaaaaaaaa for 2 accepts -> ch0 out=0xaaaaaaaa, ch1 out=0x55555555.
- Reset, mode=1, 0xabcdefab to ch0 then 15 more words of 0xabcdefab -> the second ch0 result is 0x00000000.
- Backpressure: hold out_ready=0 for 5 cycles while streaming -> in_ready=0, out/out_chan unchanged, no ptr advance. Release -> the sequence resumes with no loss or duplication.
- Reset mid-stream with 3 words in flight -> out_valid=0 after the reset edge, in-flight words dropped; the next word yields out_chan=0 with the mode-0 value equal to in.
- With MIX_SIG_EN: outputs 0x12345678 then 0xaaaaaaaa -> sig=0xb89efcd2.

Source files
------------

// File: rtl/mix_pkg.sv
// Shared definitions for the multichannel mix pipeline: operation codes,
// default parameter values and the width-generic rotate-left helper.
package mix_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_XOR  = 2'd1,
        MODE_ADD  = 2'd2,
        MODE_ROTX = 2'd3
    } mode_e;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_CHANNEL = 15;
    localparam int DEF_DEPTH   = 3;
    localparam int ROT_MAX_W   = 256;

    // Rotates the low w bits of x left by amt (amt < w, w <= ROT_MAX_W); upper bits of x must be 0.
    function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] x,
                                                  input int unsigned amt,
                                                  input int unsigned w);
        logic [ROT_MAX_W-1:0] mask;
        mask = {ROT_MAX_W{1'b1}} >> (ROT_MAX_W - w);
        return ((x << amt) | (x >> (w - amt))) & mask;
    endfunction

endpackage

// File: rtl/mix_alu.sv
// Combinational channel mixer: combines one input word with the selected
// channel accumulator according to the operation mode.
module mix_alu
    import mix_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = 4
) (
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic [CW-1:0]    idx_i,
    output logic [WIDTH-1:0] r_o
);

    localparam int unsigned WU = WIDTH;

    int unsigned rot_amt;

    always_comb begin
        rot_amt = 32'(idx_i) % WU;
        r_o     = in_i;
        case (mode_e'(mode_i))
            MODE_PASS: r_o = in_i;
            MODE_XOR:  r_o = acc_i ^ in_i;
            MODE_ADD:  r_o = acc_i + in_i;
            MODE_ROTX: r_o = acc_i ^ WIDTH'(rotl(ROT_MAX_W'(in_i), rot_amt, WU));
            default:   r_o = in_i;
        endcase
    end

endmodule

// File: rtl/multichan_mix_pipe.sv
// Round-robin multichannel accumulate/mix stage followed by a stallable
// DEPTH-stage output pipeline. Define MIX_SIG_EN to add the sig output.
module multichan_mix_pipe
    import mix_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int CHANNEL = DEF_CHANNEL,
    parameter  int DEPTH   = DEF_DEPTH,
    localparam int CW      = $clog2(CHANNEL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    out_chan,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MIX_SIG_EN
    ,
    output logic [WIDTH-1:0] sig
`endif
);

    // Handshake: a word transfers on in when in_valid && in_ready, and on out
    // when out_valid && out_ready; the pipeline moves as a whole only when the
    // last stage is empty or being drained.
    logic [WIDTH-1:0] acc_q [CHANNEL];
    logic [CW-1:0]    ptr_q;
    logic [CW-1:0]    ptr_d;
    logic [WIDTH-1:0] mix_r;
    logic             adv;
    logic             accept;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;
    assign accept   = in_valid && in_ready;
    assign ptr_d    = (ptr_q == CW'(CHANNEL - 1)) ? '0 : ptr_q + CW'(1);

    mix_alu #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_alu (
        .mode_i (mode),
        .acc_i  (acc_q[ptr_q]),
        .in_i   (in),
        .idx_i  (ptr_q),
        .r_o    (mix_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNEL; c++) begin
                acc_q[c] <= '0;
            end
            ptr_q <= '0;
        end else if (accept) begin
            acc_q[ptr_q] <= mix_r;
            ptr_q        <= ptr_d;
        end
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic [WIDTH-1:0] data_q;
        logic [CW-1:0]    chan_q;
        logic             vld_q;

        if (s == 0) begin : g_first
            // A cycle that advances without an accept inserts a bubble.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                    chan_q <= '0;
                    vld_q  <= 1'b0;
                end else if (adv) begin
                    vld_q <= accept;
                    if (accept) begin
                        data_q <= mix_r;
                        chan_q <= ptr_q;
                    end
                end
            end
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                    chan_q <= '0;
                    vld_q  <= 1'b0;
                end else if (adv) begin
                    data_q <= g_stage[s-1].data_q;
                    chan_q <= g_stage[s-1].chan_q;
                    vld_q  <= g_stage[s-1].vld_q;
                end
            end
        end
    end

    assign out       = g_stage[DEPTH-1].data_q;
    assign out_chan  = g_stage[DEPTH-1].chan_q;
    assign out_valid = g_stage[DEPTH-1].vld_q;

`ifdef MIX_SIG_EN
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    assign sig_d = sig_q ^ out;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else if (out_valid && out_ready) begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`endif

endmodule

// File: tb/tb_multichan_mix_pipe.sv
// Scoreboard bench for multichan_mix_pipe: directed vectors push expected
// {chan, data} pairs on accept; a negedge monitor pops on each output transfer.
module tb_multichan_mix_pipe;
    import mix_pkg::*;

    localparam int WIDTH   = 32;
    localparam int CHANNEL = 15;
    localparam int DEPTH   = 3;
    localparam int CW      = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_chan;
    logic             out_valid;
    logic             out_ready;
`ifdef MIX_SIG_EN
    logic [WIDTH-1:0] sig;
`endif

    logic [CW+WIDTH-1:0] exp_q[$];
    int n_checks;
    int n_fail;
    int stall_cycles;

    multichan_mix_pipe #(
        .WIDTH   (WIDTH),
        .CHANNEL (CHANNEL),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .out       (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MIX_SIG_EN
        ,
        .sig       (sig)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks (inputs change at posedge+1)
    task automatic send(input logic [1:0] m, input logic [WIDTH-1:0] d,
                        input logic [CW-1:0] ec, input logic [WIDTH-1:0] ed);
        bit done;
        done     = 1'b0;
        mode     = m;
        in_data  = d;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({ec, ed});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected accept");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out_data, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [CW+WIDTH-1:0] e;
        logic [WIDTH-1:0]    prev_out;
        logic [CW-1:0]       prev_chan;
        bit                  prev_stall;
        prev_stall = 1'b0;
        prev_out   = '0;
        prev_chan  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid && !out_ready) begin
                    stall_cycles++;
                    check("stall_in_ready", in_ready, 0);
                    if (prev_stall) begin
                        check("stall_out_hold", out_data, prev_out);
                        check("stall_chan_hold", out_chan, prev_chan);
                    end
                    prev_stall = 1'b1;
                end else begin
                    prev_stall = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got chan %0d data 0x%0h, expected none",
                                 out_chan, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e[WIDTH-1:0]);
                        check("out_chan", out_chan, e[CW+WIDTH-1:WIDTH]);
                    end
                end
                prev_out  = out_data;
                prev_chan = out_chan;
            end
        end
    end

    // Directed stimulus
    initial begin
        n_checks     = 0;
        n_fail       = 0;
        stall_cycles = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        mode         = 2'd0;
        out_ready    = 1'b1;
        @(posedge clk);
        #1;

        // PASS single word and latency
        do_reset();
        send(2'd0, 32'habcdefab, 4'd0, 32'habcdefab);
        idle();
        @(negedge clk);
        check("lat_edge0_valid", out_valid, 0);
        check("lat_edge0_ready", in_ready, 1);
        @(negedge clk);
        check("lat_edge1_valid", out_valid, 0);
        check("lat_edge1_ready", in_ready, 1);
        @(negedge clk);
        check("lat_edge2_valid", out_valid, 1);
        check("lat_edge2_ready", in_ready, 1);
        @(posedge clk);
        #1;
        drain();

        // ADD across all channels with wrap-around
        do_reset();
        for (int i = 0; i < CHANNEL; i++) begin
            send(2'd2, 32'h12345678, CW'(i), 32'h12345678);
        end
        send(2'd2, 32'h12345678, 4'd0, 32'h2468acf0);
        idle();
        drain();

        // ROTX on channels 0 and 1
        do_reset();
        send(2'd3, 32'haaaaaaaa, 4'd0, 32'haaaaaaaa);
        send(2'd3, 32'haaaaaaaa, 4'd1, 32'h55555555);
        idle();
        drain();

        // XOR: second visit to ch0 cancels
        do_reset();
        for (int i = 0; i < CHANNEL; i++) begin
            send(2'd1, 32'habcdefab, CW'(i), 32'habcdefab);
        end
        send(2'd1, 32'habcdefab, 4'd0, 32'h00000000);
        idle();
        drain();

        // Backpressure during a PASS stream
        do_reset();
        stall_cycles = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(2'd0, 32'h1000 + i, CW'(i), 32'h1000 + i);
                end
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_cycles", 64'(stall_cycles), 64'd5);

        // Reset with three words in flight
        out_ready = 1'b0;
        send(2'd0, 32'h00000111, 4'd0, 32'h00000111);
        send(2'd0, 32'h00000222, 4'd1, 32'h00000222);
        send(2'd0, 32'h00000333, 4'd2, 32'h00000333);
        idle();
        do_reset();
        out_ready = 1'b1;
        send(2'd0, 32'hdeadbeef, 4'd0, 32'hdeadbeef);
        idle();
        drain();

`ifdef MIX_SIG_EN
        do_reset();
        check("sig_reset", sig, 0);
        send(2'd0, 32'h12345678, 4'd0, 32'h12345678);
        send(2'd0, 32'haaaaaaaa, 4'd1, 32'haaaaaaaa);
        idle();
        drain();
        check("sig_value", sig, 32'hb89efcd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
